// File: rtl/multiplex_display_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment table and blank/off patterns.
package multiplex_display_pkg;

    typedef logic [3:0] hex_t;
    typedef logic [6:0] seg_t;

    // Active-low {g,f,e,d,c,b,a}, entry 0 in the low slice.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/multiplex_display_if.sv
// Bundle of the display's digit inputs and anode/cathode drives.
interface multiplex_display_if;
    import multiplex_display_pkg::*;

    logic [7:0][3:0] digit;
    logic [7:0]      anode;
    seg_t            cathode;

    modport master (output digit, input anode, input cathode);
    modport slave  (input digit, output anode, output cathode);
endinterface

// File: rtl/multiplex_display_seg7_decoder.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
module seg7_decoder
    import multiplex_display_pkg::*;
(
    input  hex_t hex,
    output seg_t seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/multiplex_display.sv
// Eight-digit time-multiplexed 7-segment driver.
// Optional leading-zero blanking is enabled by defining MULTIPLEX_DISPLAY_LZB_EN.
module multiplex_display
    import multiplex_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] anode,
    output logic [6:0] cathode,
    input  logic [3:0] digit7,
    input  logic [3:0] digit6,
    input  logic [3:0] digit5,
    input  logic [3:0] digit4,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0
);
    localparam int unsigned     CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       sel;
    logic [7:0][3:0]  digits;
    hex_t             cur_digit;
    seg_t             seg;
    logic             blank;

    assign digits = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

    always_comb cur_digit = digits[sel];

    seg7_decoder u_dec (
        .hex (cur_digit),
        .seg (seg)
    );

`ifdef MULTIPLEX_DISPLAY_LZB_EN
    // nz[k] is set when digit k or any higher digit is non-zero.
    logic [7:0] nz;

    always_comb begin
        nz    = '0;
        nz[7] = |digits[7];
        for (int unsigned i = 1; i < 8; i++) begin
            nz[3'(7 - i)] = nz[3'(8 - i)] | (|digits[3'(7 - i)]);
        end
        blank = (sel != 3'd0) && !nz[sel];
    end
`else
    assign blank = 1'b0;
`endif

    // anode and cathode both come from the pre-increment sel so they always agree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            sel     <= '0;
            anode   <= ANODE_OFF;
            cathode <= SEG_BLANK;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                sel <= sel + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            anode   <= ~(8'b1 << sel);
            cathode <= blank ? SEG_BLANK : seg;
        end
    end

endmodule

// File: tb/tb_multiplex_display.sv
// Scoreboard bench for multiplex_display: REFRESH_DIV=4 and REFRESH_DIV=1 instances share inputs.
module tb_multiplex_display;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multiplex_display_if dif ();
    logic [7:0] an1;
    logic [6:0] ca1;

`ifdef MULTIPLEX_DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    multiplex_display #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .anode(dif.anode), .cathode(dif.cathode),
        .digit7(dif.digit[7]), .digit6(dif.digit[6]), .digit5(dif.digit[5]), .digit4(dif.digit[4]),
        .digit3(dif.digit[3]), .digit2(dif.digit[2]), .digit1(dif.digit[1]), .digit0(dif.digit[0])
    );

    multiplex_display #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .anode(an1), .cathode(ca1),
        .digit7(dif.digit[7]), .digit6(dif.digit[6]), .digit5(dif.digit[5]), .digit4(dif.digit[4]),
        .digit3(dif.digit[3]), .digit2(dif.digit[2]), .digit1(dif.digit[1]), .digit0(dif.digit[0])
    );

    typedef struct {
        string      name;
        bit         chk4;
        logic [7:0] an;
        logic [6:0] ca;
        bit         chk1;
        logic [7:0] an1;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] ca_scan [8] = '{7'b1111001, 7'b0100100, 7'b0011001, 7'b0000010,
                                7'b0011001, 7'b0000010, 7'b0011001, 7'b0100100};

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: ref_seg = 7'b1000000;
            4'h1: ref_seg = 7'b1111001;
            4'h2: ref_seg = 7'b0100100;
            4'h3: ref_seg = 7'b0110000;
            4'h4: ref_seg = 7'b0011001;
            4'h5: ref_seg = 7'b0010010;
            4'h6: ref_seg = 7'b0000010;
            4'h7: ref_seg = 7'b1111000;
            4'h8: ref_seg = 7'b0000000;
            4'h9: ref_seg = 7'b0010000;
            4'hA: ref_seg = 7'b0001000;
            4'hB: ref_seg = 7'b0000011;
            4'hC: ref_seg = 7'b1000110;
            4'hD: ref_seg = 7'b0100001;
            4'hE: ref_seg = 7'b0000110;
            default: ref_seg = 7'b0001110;
        endcase
    endfunction

    // Monitor: each expectation pushed at a falling edge is checked just after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk4) begin
                checks++;
                if (dif.anode !== e.an) begin
                    errors++;
                    $display("FAIL %s anode: got %h expected %h at %0t", e.name, dif.anode, e.an, $time);
                end
                checks++;
                if (dif.cathode !== e.ca) begin
                    errors++;
                    $display("FAIL %s cathode: got %b expected %b at %0t", e.name, dif.cathode, e.ca, $time);
                end
            end
            if (e.chk1) begin
                checks++;
                if (an1 !== e.an1) begin
                    errors++;
                    $display("FAIL %s div1 anode: got %h expected %h at %0t", e.name, an1, e.an1, $time);
                end
            end
        end
    end

    task automatic tick(input bit chk4, input string nm, input logic [7:0] an, input logic [6:0] ca,
                        input bit chk1, input logic [7:0] a1);
        exp_t x;
        x.name = nm; x.chk4 = chk4; x.an = an; x.ca = ca; x.chk1 = chk1; x.an1 = a1;
        if (chk4 || chk1) q.push_back(x);
        @(negedge clk);
    endtask

    task automatic set_digits(input logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0);
        dif.digit = {d7, d6, d5, d4, d3, d2, d1, d0};
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick(0, "", 8'h00, 7'h00, 0, 8'h00);
        rst_n = 1'b1;
    endtask

    logic [6:0] lzb_ca;

    initial begin
        rst_n = 1'b0;
        set_digits(4'h2, 4'h4, 4'h6, 4'h4, 4'h6, 4'h4, 4'h2, 4'h1);
        @(negedge clk);
        tick(0, "", 8'h00, 7'h00, 0, 8'h00);
        tick(1, "reset", 8'hFF, 7'h7F, 1, 8'hFF);

        // Full scan plus one wrap; the div-1 instance steps every cycle.
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++)
            tick(1, "scan", an_tab[(i / 4) % 8], ca_scan[(i / 4) % 8], 1, an_tab[i % 8]);

        // Mid-scan reset for three cycles, then release.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) tick(1, "midrst", 8'hFF, 7'h7F, 1, 8'hFF);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick(1, "release", 8'hFE, 7'b1111001, 1, an_tab[k]);

        // Decode sweep on position 0.
        for (int v = 0; v < 16; v++) begin
            rst_n = 1'b0;
            dif.digit[0] = 4'(v);
            tick(0, "", 8'h00, 7'h00, 0, 8'h00);
            rst_n = 1'b1;
            tick(1, "decode", 8'hFE, ref_seg(4'(v)), 0, 8'h00);
        end

        // Live update while position 3 is lit (edges 13..16 after release).
        set_digits(4'h2, 4'h4, 4'h6, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1);
        restart();
        for (int k = 0; k < 12; k++) tick(0, "", 8'h00, 7'h00, 0, 8'h00);
        tick(1, "live_pre", 8'hF7, 7'b0000000, 0, 8'h00);
        dif.digit[3] = 4'hF;
        tick(1, "live_post", 8'hF7, 7'b0001110, 0, 8'h00);

        // Leading-zero pattern 0,0,0,0,0,1,0,0.
        set_digits(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        restart();
        for (int i = 0; i < 32; i++) begin
            if (i / 4 == 2)      lzb_ca = 7'b1111001;
            else if (i / 4 < 2)  lzb_ca = 7'b1000000;
            else                 lzb_ca = LZB ? 7'h7F : 7'b1000000;
            tick(1, "lzb_pat", an_tab[i / 4], lzb_ca, 0, 8'h00);
        end

        // All zeros: only position 0 survives blanking.
        set_digits(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        restart();
        for (int i = 0; i < 32; i++) begin
            lzb_ca = (i / 4 == 0) ? 7'b1000000 : (LZB ? 7'h7F : 7'b1000000);
            tick(1, "lzb_zero", an_tab[i / 4], lzb_ca, 0, 8'h00);
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
